// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction prefetch unit.
//   ifetch_state_e : bus controller states (IDLE=0, FETCH=1, DISCARD=2)
//   WORD_BYTES     : byte stride between consecutive instruction words
//   WB_SEL         : Wishbone byte-select for full-word reads
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } ifetch_state_e;

  localparam logic [31:0] WORD_BYTES = 32'd4;
  localparam logic [3:0]  WB_SEL     = 4'hF;

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: small word FIFO holding prefetched instructions.
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : empty the FIFO; a push on the same edge becomes the sole entry
//   push        : write push_data at the tail
//   pop         : drop the head entry
//   head_data   : oldest stored word
//   count       : number of stored words (0..DEPTH)
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [31:0]   push_data,
  input  logic          pop,
  output logic [31:0]   head_data,
  output logic [CW-1:0] count
);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_idx;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A flush restarts both pointers at slot 0, so a word pushed on the same
  // edge lands there and is immediately the head.
  assign wr_idx = flush ? '0 : wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? ptr_inc('0) : '0;
      count  <= push ? CW'(1) : '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch: instruction prefetch buffer between the CPU fetch port and
// a Wishbone SPI instruction memory. One bus read outstanding at a time.
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_i, addr_i     : CPU fetch request and word-aligned byte address
//   flush_i           : drop buffered and in-flight words (branch/trap)
//   ready_o, instr_o  : request completes this cycle with instr_o (0 otherwise)
//   adr_o, cyc_o, stb_o, we_o, sel_o : Wishbone master outputs (read only)
//   dat_i, ack_i      : Wishbone read data and acknowledge
// Build option: define IFETCH_PREFETCH_EN to fetch speculatively whenever the
// buffer has room (DEPTH words). Without it, reads are issued on demand only
// and the buffer holds a single word.
module ifetch_prefetch
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        flush_i,
  output logic        ready_o,
  output logic [31:0] instr_o,
  output logic [31:0] adr_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [3:0]  sel_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i
);

`ifdef IFETCH_PREFETCH_EN
  localparam int unsigned BUF_DEPTH = DEPTH;
`else
  localparam int unsigned BUF_DEPTH = 1;
`endif
  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

  if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
    $error("ifetch_prefetch: DEPTH must be in 1..8");
  end

  ifetch_state_e state, state_nxt;
  logic [31:0]   next_addr, next_nxt;
  logic [31:0]   head_addr, head_nxt;
  logic [31:0]   redirect, redir_nxt;
  logic [31:0]   adr_nxt;
  logic [31:0]   head_data;
  logic [CW-1:0] count;
  logic          push, pop, fifo_clr;
  logic          hit, miss, want_fetch;

  ifetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (fifo_clr),
    .push      (push),
    .push_data (dat_i),
    .pop       (pop),
    .head_data (head_data),
    .count     (count)
  );

  // An empty buffer with addr_i == next_addr is the word about to be (or
  // being) fetched, so that case waits rather than redirecting.
  assign hit  = req_i && !flush_i && (count != '0) && (addr_i == head_addr);
  assign miss = req_i && !flush_i && !hit && ((count != '0) || (addr_i != next_addr));

`ifdef IFETCH_PREFETCH_EN
  assign want_fetch = (count < CW'(BUF_DEPTH));
`else
  assign want_fetch = req_i && !flush_i && (count == '0) && (addr_i == next_addr);
`endif

  assign ready_o = hit;
  assign instr_o = hit ? head_data : '0;
  assign cyc_o   = (state != IDLE);
  assign stb_o   = cyc_o;
  assign we_o    = 1'b0;
  assign sel_o   = WB_SEL;

  always_comb begin
    state_nxt = state;
    adr_nxt   = adr_o;
    next_nxt  = next_addr;
    head_nxt  = head_addr;
    redir_nxt = redirect;
    push      = 1'b0;
    pop       = 1'b0;
    fifo_clr  = 1'b0;

    if (hit) begin
      pop      = 1'b1;
      head_nxt = head_addr + WORD_BYTES;
    end

    unique case (state)
      IDLE: begin
        if (flush_i) begin
          fifo_clr = 1'b1;
          head_nxt = next_addr;
        end else if (miss) begin
          fifo_clr  = 1'b1;
          head_nxt  = addr_i;
          next_nxt  = addr_i;
          adr_nxt   = addr_i;
          state_nxt = FETCH;
        end else if (want_fetch) begin
          adr_nxt   = next_addr;
          state_nxt = FETCH;
        end
      end

      FETCH: begin
        if (flush_i) begin
          // In-flight word is dropped; resume from it unless a request
          // redirects us before the ack arrives.
          fifo_clr  = 1'b1;
          head_nxt  = next_addr;
          redir_nxt = next_addr;
          state_nxt = ack_i ? IDLE : DISCARD;
        end else if (miss && (addr_i != next_addr)) begin
          fifo_clr  = 1'b1;
          head_nxt  = addr_i;
          redir_nxt = addr_i;
          if (ack_i) begin
            next_nxt  = addr_i;
            state_nxt = IDLE;
          end else begin
            state_nxt = DISCARD;
          end
        end else begin
          // Miss on the word already in flight: keep it, drop the rest.
          if (miss) begin
            fifo_clr = 1'b1;
            head_nxt = addr_i;
          end
          if (ack_i) begin
            push      = 1'b1;
            next_nxt  = next_addr + WORD_BYTES;
            state_nxt = IDLE;
          end
        end
      end

      DISCARD: begin
        if (req_i) begin
          redir_nxt = addr_i;
          head_nxt  = addr_i;
        end
        if (ack_i) begin
          next_nxt  = redir_nxt;
          head_nxt  = redir_nxt;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      adr_o     <= '0;
      next_addr <= RESET_ADDR;
      head_addr <= RESET_ADDR;
      redirect  <= RESET_ADDR;
    end else begin
      state     <= state_nxt;
      adr_o     <= adr_nxt;
      next_addr <= next_nxt;
      head_addr <= head_nxt;
      redirect  <= redir_nxt;
    end
  end

endmodule
